acc_su8: RTL
============

ACC_SU8 -- requirements
Module: acc_su8

Interface
- REQ-001: Parameter ACC_W, default 16: accumulator and result width in bits; legal range 9..32.
- REQ-002: Parameter LEN_W, default 4: width of the vector-length field; sets the maximum vector length to 2^LEN_W products.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  reset, asynchronous and active-high.
- REQ-005: start  input  1  begin a new accumulation; sampled only in IDLE.
- REQ-006: len_m1  input  LEN_W  number of products in the vector minus one; sampled when start is accepted.
- REQ-007: in_valid  input  1  the prod input carries a valid product.
- REQ-008: in_ready  output  1  the block accepts a product this cycle.
- REQ-009: prod  input  8  signed two's-complement product from the 4x4 signed-by-unsigned multiplier stage.
- REQ-010: out_valid  output  1  acc_out and ovf hold a completed result.
- REQ-011: out_ready  input  1  the downstream consumer takes the result.
- REQ-012: acc_out  output  ACC_W  signed accumulated sum.
- REQ-013: ovf  output  1  sticky flag: saturation occurred during the current vector.
- REQ-014: busy  output  1  high in every state other than IDLE.

Function
- REQ-015: The FSM SHALL have three states: IDLE, ACCUM and DONE.
- REQ-016: IDLE, start=1: latch len_m1, clear the accumulator and ovf, and clear the beat counter; go to ACCUM on the next edge.
- REQ-017: ACCUM: in_ready SHALL be 1.
- REQ-018: ACCUM beat: a beat is in_valid&&in_ready; each beat SHALL add prod, sign-extended to ACC_W, to the accumulator and increment the counter.
- REQ-019: ACCUM, no beat: in_valid=0 SHALL leave the accumulator and counter unchanged, with no timeout.
- REQ-020: ACCUM exit: the beat taken when counter==latched len_m1 SHALL be the last; go to DONE on the same edge.
- REQ-021: Saturation: the sum SHALL saturate to +(2^(ACC_W-1)-1) or -2^(ACC_W-1); any saturating beat SHALL set ovf, and ovf SHALL stay set until the next accepted start.
- REQ-022: DONE: out_valid=1; acc_out and ovf SHALL stay stable until out_valid&&out_ready.
- REQ-023: DONE exit: on out_valid&&out_ready, go to IDLE on the next edge.
- REQ-024: Latency: out_valid SHALL rise exactly one cycle after the last beat; from a start edge to result with no stalls takes len_m1+2 cycles.
- REQ-025: start in ACCUM or DONE SHALL be ignored, with no effect on state.
- REQ-026: in_ready SHALL be 0 in IDLE and DONE; in_valid there is ignored, including start and in_valid asserted in the same cycle in IDLE.
- REQ-027: len_m1=0 SHALL give a single-beat vector; len_m1=2^LEN_W-1 SHALL give the full length, with no counter wrap before the exit.
- REQ-028: acc_out SHALL show the live accumulator in all states; it is defined as a result only while out_valid=1.

Reset
- REQ-029: rst=1 SHALL force, asynchronously, state=IDLE; accumulator, counter and latched length to 0; and in_ready=0, out_valid=0, ovf=0, busy=0, acc_out=0.
- REQ-030: Reset asserted mid-ACCUM or mid-DONE SHALL abandon the vector, with no result emitted after release.
- REQ-031: The first start is accepted on the first rising edge after rst deasserts.

Structure
- REQ-032: A shared package SHALL hold the state enumeration (IDLE, ACCUM, DONE), the default ACC_W (16) and LEN_W (4), and the product width constant (8).
- REQ-033: One sub-module, sat_add, SHALL implement the combinational signed saturating add (ACC_W accumulator plus sign-extended 8-bit operand) and output {sum, sat}.
- REQ-034: All other logic (FSM, counter, registers) SHALL be in acc_su8.

Verification
- REQ-035: Basic: len_m1=3, prods 10, 20, -5, 7 with no stalls -> out_valid 5 cycles after start, acc_out=32 (0x0020), ovf=0.
- REQ-036: Single beat / negative: len_m1=0, prod=-120 -> acc_out=0xFF88, ovf=0, back to IDLE after out_ready.
- REQ-037: Saturation: ACC_W=10, len_m1=4, five prods of 105 -> acc_out=511, ovf=1; following vector len_m1=0, prod=1 -> acc_out=1, ovf=0.
- REQ-038: Stalls and backpressure: in_valid toggled 1,0,0,1 across two products (5, -3), out_ready held low 3 cycles -> acc_out=2 held stable while out_valid=1; single handoff.
- REQ-039: Ignored start: start pulsed in ACCUM and in DONE -> no length relatch, no accumulator clear, result unchanged.
- REQ-040: Reset mid-vector: rst asserted after 2 of 4 beats -> outputs 0 immediately; new vector len_m1=1, prods 3, 4 -> acc_out=7.

Source files
------------

// File: rtl/acc_su8_pkg.sv
// Shared types and constants for the signed-by-unsigned product accumulator.
package acc_su8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int ACC_W_DEF = 16;
  localparam int LEN_W_DEF = 4;
  localparam int PROD_W    = 8;

endpackage

// File: rtl/sat_add.sv
// Signed saturating add of a sign-extended 8-bit product onto the accumulator.
module sat_add
  import acc_su8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] op_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              sat_o
);

  logic [ACC_W:0] wide;

  // One guard bit catches overflow; clamp to the signed extreme on overflow.
  always_comb begin
    wide  = {acc_i[ACC_W-1], acc_i} + {{(ACC_W + 1 - PROD_W){op_i[PROD_W-1]}}, op_i};
    sat_o = wide[ACC_W] ^ wide[ACC_W-1];
    if (sat_o) begin
      sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum_o = wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/acc_su8.sv
// Vector accumulator: sums a run of signed 8-bit products with saturation and
// hands the result off through a valid/ready output.
module acc_su8
  import acc_su8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_m1,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              busy
);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovf_q;
  logic               sat_d;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc_i (acc_q),
    .op_i  (prod),
    .sum_o (acc_d),
    .sat_o (sat_d)
  );

  // Control FSM plus accumulator, beat counter, latched length and sticky ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= len_m1;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            if (sat_d) begin
              ovf_q <= 1'b1;
            end
            if (cnt_q == len_q) begin
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule
